// File: rtl/prng_pkg.sv
// Shared types and constants for the PRNG sequencing controller.
// Holds the FSM encoding, the LFSR lock-up value and default widths.
package prng_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        SEED = 2'd3
    } state_t;

    localparam logic [15:0] LOCKUP_VALUE = 16'hFFFF;
    localparam int          DATA_W       = 16;
    localparam int          CTRL_W       = 8;
    localparam int          CNT_W_DEF    = 24;

endpackage

// File: rtl/prng_seq_ctrl_if.sv
// LFSR control strobes plus the sample valid/ready handshake to the consumer.
// master = sequencing controller, slave = LFSR datapath / sample consumer.
interface prng_seq_ctrl_if;
    import prng_pkg::*;

    logic              data_step;
    logic              ctrl_step;
    logic              seed_load;
    logic [DATA_W-1:0] seed_out;
    logic [DATA_W-1:0] data_state;
    logic [CTRL_W-1:0] mux_in;
    logic [CTRL_W-1:0] sample;
    logic              sample_valid;
    logic              sample_ready;

    modport master (
        output data_step, ctrl_step, seed_load, seed_out, sample, sample_valid,
        input  data_state, mux_in, sample_ready
    );

    modport slave (
        input  data_step, ctrl_step, seed_load, seed_out, sample, sample_valid,
        output data_state, mux_in, sample_ready
    );

endinterface

// File: rtl/prng_prescaler.sv
// Step-enable prescaler: counts 0..DIV-1 while en, tick in the DIV-1 cycle, then wraps.
// Latency: first tick DIV cycles after en rises from a cleared count; no backpressure.
module prng_prescaler #(
    parameter int               CNT_W = 24,
    parameter logic [CNT_W-1:0] DIV   = CNT_W'(2)
) (
    input  logic CLK,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    logic [CNT_W-1:0] cnt;
    logic             term;

    assign term = (cnt == DIV - CNT_W'(1));
    assign tick = en && term;

    always_ff @(posedge CLK) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= term ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/prng_seq_ctrl.sv
// PRNG sequencer: run/stop/step/seed FSM driving LFSR step strobes, sample capture two cycles after data_step.
// Latency: step cmd -> data_step next cycle -> sample_valid 2 cycles later; overwrite on stall sets overrun. Option: PRNG_LOCKUP_GUARD_EN.
module prng_seq_ctrl
    import prng_pkg::*;
#(
    parameter int               CNT_W        = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DATA_DIV     = CNT_W'(10_000_000),
    parameter logic [CNT_W-1:0] CTRL_DIV     = CNT_W'(1_250_000),
    parameter logic [15:0]      DEFAULT_SEED = 16'h0001
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               EN,
    input  logic               cmd_run,
    input  logic               cmd_step,
    input  logic               cmd_seed,
    input  logic [DATA_W-1:0]  seed_in,
    output logic               overrun,
    output logic               busy,
    prng_seq_ctrl_if.master    bus
);

    state_t            state, state_nxt;
    logic              take_seed;
    logic              lockup_hit;
    logic              pre_en, pre_clr;
    logic              data_tick, ctrl_tick;
    logic              cap_pend;
    logic [DATA_W-1:0] seed_reg;
    logic [CTRL_W-1:0] sample_q;
    logic              valid_q;
    logic              overrun_q;

    // Prescalers only count while resting in RUN; any exit or stay outside RUN zeroes them.
    assign pre_en  = EN && (state == RUN);
    assign pre_clr = !EN || (state != RUN) || (state_nxt != RUN);

    prng_prescaler #(.CNT_W(CNT_W), .DIV(DATA_DIV)) u_data_pre (
        .CLK(CLK), .reset(reset), .clr(pre_clr), .en(pre_en), .tick(data_tick)
    );

    prng_prescaler #(.CNT_W(CNT_W), .DIV(CTRL_DIV)) u_ctrl_pre (
        .CLK(CLK), .reset(reset), .clr(pre_clr), .en(pre_en), .tick(ctrl_tick)
    );

`ifdef PRNG_LOCKUP_GUARD_EN
    assign lockup_hit = cap_pend && (bus.data_state == LOCKUP_VALUE);
`else
    assign lockup_hit = 1'b0;
    wire unused_guard = ^{bus.data_state, LOCKUP_VALUE, DEFAULT_SEED};
`endif

    always_comb begin
        state_nxt = state;
        take_seed = 1'b0;
        if (!EN) begin
            state_nxt = IDLE;
        end else if (lockup_hit) begin
            state_nxt = SEED;
        end else begin
            case (state)
                IDLE, RUN: begin
                    if (cmd_seed) begin
                        state_nxt = SEED;
                        take_seed = 1'b1;
                    end else if (cmd_step) begin
                        state_nxt = STEP;
                    end else if (cmd_run) begin
                        state_nxt = RUN;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = cmd_run ? RUN : IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state    <= IDLE;
            seed_reg <= '0;
        end else begin
            state <= state_nxt;
            if (EN && lockup_hit) begin
                seed_reg <= DEFAULT_SEED;
            end else if (take_seed) begin
                seed_reg <= seed_in;
            end
        end
    end

    assign bus.data_step = EN && ((state == STEP) || data_tick);
    assign bus.ctrl_step = EN && ((state == STEP) || ctrl_tick);
    assign bus.seed_load = EN && (state == SEED);
    assign bus.seed_out  = seed_reg;
    assign busy          = (state != IDLE);

    // cap_pend marks the cycle in which the LFSR shows its freshly stepped value.
    always_ff @(posedge CLK) begin
        if (reset) begin
            cap_pend  <= 1'b0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            cap_pend <= bus.data_step;
            if (cap_pend) begin
                sample_q <= bus.mux_in;
                valid_q  <= 1'b1;
                if (valid_q && !bus.sample_ready) begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && bus.sample_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.sample       = sample_q;
    assign bus.sample_valid = valid_q;
    assign overrun          = overrun_q;

endmodule

// File: tb/tb_prng_seq_ctrl.sv
// Scoreboard bench for prng_seq_ctrl with DATA_DIV=4, CTRL_DIV=3: stimulus pushes expected
// pulse cycles and sample values; a negedge monitor pops and compares as the DUT presents them.
module tb_prng_seq_ctrl;

    logic        CLK = 1'b0;
    logic        reset, EN, cmd_run, cmd_step, cmd_seed;
    logic [15:0] seed_in;
    logic        overrun, busy;

    prng_seq_ctrl_if bus();

    prng_seq_ctrl #(
        .CNT_W(24), .DATA_DIV(24'd4), .CTRL_DIV(24'd3), .DEFAULT_SEED(16'h0001)
    ) dut (
        .CLK(CLK), .reset(reset), .EN(EN), .cmd_run(cmd_run), .cmd_step(cmd_step),
        .cmd_seed(cmd_seed), .seed_in(seed_in), .overrun(overrun), .busy(busy), .bus(bus)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    int          dq[$];
    int          cq[$];
    int          rq[$];
    int          lq[$];
    logic [15:0] lvq[$];
    logic [7:0]  sq[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge CLK);
            #1;
        end
    endtask

    int          mon_e;
    logic [15:0] mon_v;
    logic        prev_valid = 1'b0;

    always @(negedge CLK) begin
        if (bus.data_step === 1'b1) begin
            mon_e = -1;
            if (dq.size() > 0) mon_e = dq.pop_front();
            check("data_step_cycle", cyc, mon_e);
        end
        if (bus.ctrl_step === 1'b1) begin
            mon_e = -1;
            if (cq.size() > 0) mon_e = cq.pop_front();
            check("ctrl_step_cycle", cyc, mon_e);
        end
        if (bus.seed_load === 1'b1) begin
            mon_e = -1;
            mon_v = 16'hDEAD;
            if (lq.size() > 0) begin
                mon_e = lq.pop_front();
                mon_v = lvq.pop_front();
            end
            check("seed_load_cycle", cyc, mon_e);
            check("seed_out_value", {16'h0, bus.seed_out}, {16'h0, mon_v});
        end
        if (bus.sample_valid === 1'b1 && prev_valid !== 1'b1) begin
            mon_e = -1;
            if (rq.size() > 0) mon_e = rq.pop_front();
            check("valid_rise_cycle", cyc, mon_e);
        end
        if (bus.sample_valid === 1'b1 && bus.sample_ready === 1'b1) begin
            mon_v = 16'hDEAD;
            if (sq.size() > 0) mon_v = {8'h0, sq.pop_front()};
            check("accepted_sample", {24'h0, bus.sample}, {16'h0, mon_v});
        end
        prev_valid <= bus.sample_valid;
    end

    int b0, r1, s, r2, t2, u, r3, r4, f;
`ifdef PRNG_LOCKUP_GUARD_EN
    int g;
`endif

    initial begin
        reset = 1'b1; EN = 1'b1; cmd_run = 1'b1; cmd_step = 1'b0; cmd_seed = 1'b0;
        seed_in = 16'h0;
        bus.sample_ready = 1'b1; bus.mux_in = 8'h3C; bus.data_state = 16'h0000;

        repeat (3) @(posedge CLK);
        #1;
        check("rst_pulses", {29'h0, bus.data_step, bus.ctrl_step, bus.seed_load}, 32'h0);
        check("rst_valid_ovr_busy", {29'h0, bus.sample_valid, overrun, busy}, 32'h0);
        check("rst_seed_out", {16'h0, bus.seed_out}, 32'h0);
        check("rst_sample", {24'h0, bus.sample}, 32'h0);

        // Free run out of reset: RUN from cycle r1.
        b0 = cyc;
        reset = 1'b0;
        r1 = b0 + 1;
        dq.push_back(r1 + 3); dq.push_back(r1 + 7);
        cq.push_back(r1 + 2); cq.push_back(r1 + 5); cq.push_back(r1 + 8);
        rq.push_back(r1 + 5); rq.push_back(r1 + 9);
        sq.push_back(8'h3C); sq.push_back(8'h3C);

        // Seed during RUN at a cycle with no terminal count.
        s = r1 + 9;
        wait_to(s);
        bus.mux_in = 8'h5A; seed_in = 16'h1234; cmd_seed = 1'b1;
        lq.push_back(s + 1); lvq.push_back(16'h1234);
        wait_to(s + 1);
        cmd_seed = 1'b0;
        check("seed_busy", {31'h0, busy}, 32'h1);
        r2 = s + 2;
        dq.push_back(r2 + 3); dq.push_back(r2 + 7);
        cq.push_back(r2 + 2); cq.push_back(r2 + 5); cq.push_back(r2 + 8);
        rq.push_back(r2 + 5); rq.push_back(r2 + 9);
        sq.push_back(8'h5A); sq.push_back(8'h5A);

        // Stop on a ctrl terminal-count cycle: that pulse still fires.
        wait_to(r2 + 8);
        cmd_run = 1'b0;

        // Single step from IDLE.
        t2 = r2 + 12;
        wait_to(t2);
        check("idle_busy", {31'h0, busy}, 32'h0);
        bus.mux_in = 8'hA5; cmd_step = 1'b1;
        dq.push_back(t2 + 1); cq.push_back(t2 + 1); rq.push_back(t2 + 3); sq.push_back(8'hA5);
        wait_to(t2 + 1);
        cmd_step = 1'b0;
        check("step_busy", {31'h0, busy}, 32'h1);
        wait_to(t2 + 2);
        check("step_back_idle", {31'h0, busy}, 32'h0);

        // Two captures with the consumer stalled.
        wait_to(t2 + 4);
        bus.sample_ready = 1'b0;
        u = t2 + 5;
        wait_to(u);
        bus.mux_in = 8'h11; cmd_step = 1'b1;
        dq.push_back(u + 1); cq.push_back(u + 1); rq.push_back(u + 3);
        wait_to(u + 1);
        cmd_step = 1'b0;
        wait_to(u + 3);
        check("ovr_first_capture", {30'h0, bus.sample_valid, overrun}, 32'h2);
        bus.mux_in = 8'h22;
        wait_to(u + 4);
        cmd_step = 1'b1;
        dq.push_back(u + 5); cq.push_back(u + 5);
        wait_to(u + 5);
        cmd_step = 1'b0;
        wait_to(u + 7);
        check("ovr_set", {31'h0, overrun}, 32'h1);
        check("ovr_sample_second", {24'h0, bus.sample}, 32'h22);
        sq.push_back(8'h22);
        wait_to(u + 8);
        bus.sample_ready = 1'b1;
        wait_to(u + 10);
        check("ovr_valid_dropped", {31'h0, bus.sample_valid}, 32'h0);
        check("ovr_sticky", {31'h0, overrun}, 32'h1);

        // EN dropped mid-RUN, then restored.
        r3 = u + 12;
        wait_to(u + 11);
        bus.mux_in = 8'h77; cmd_run = 1'b1;
        dq.push_back(r3 + 3); cq.push_back(r3 + 2); cq.push_back(r3 + 5);
        rq.push_back(r3 + 5); sq.push_back(8'h77);
        wait_to(r3 + 6);
        EN = 1'b0; bus.mux_in = 8'h99;
        wait_to(r3 + 8);
        check("en_off_idle", {31'h0, busy}, 32'h0);
        check("en_off_sample_kept", {24'h0, bus.sample}, 32'h77);
        wait_to(r3 + 11);
        EN = 1'b1; bus.mux_in = 8'h88;
        r4 = r3 + 12;
        dq.push_back(r4 + 3); cq.push_back(r4 + 2); cq.push_back(r4 + 5);
        rq.push_back(r4 + 5); sq.push_back(8'h88);
        wait_to(r4 + 6);
        cmd_run = 1'b0;

`ifdef PRNG_LOCKUP_GUARD_EN
        g = r4 + 9;
        wait_to(g);
        bus.data_state = 16'hFFFF; bus.mux_in = 8'hC3; cmd_step = 1'b1;
        dq.push_back(g + 1); cq.push_back(g + 1); rq.push_back(g + 3); sq.push_back(8'hC3);
        lq.push_back(g + 3); lvq.push_back(16'h0001);
        wait_to(g + 1);
        cmd_step = 1'b0;
        wait_to(g + 6);
        bus.data_state = 16'h0000;
`endif

        f = r4 + 20;
        wait_to(f);
        check("ovr_before_reset", {31'h0, overrun}, 32'h1);
        reset = 1'b1;
        wait_to(f + 1);
        check("ovr_cleared_by_reset", {31'h0, overrun}, 32'h0);
        reset = 1'b0;
        wait_to(f + 4);

        check("data_step_left", dq.size(), 32'h0);
        check("ctrl_step_left", cq.size(), 32'h0);
        check("valid_rise_left", rq.size(), 32'h0);
        check("sample_left", sq.size(), 32'h0);
        check("seed_load_left", lq.size(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
